// File: rtl/gcd_lcm_seq_alu.sv
// Multi-cycle GCD / LCM / ceil-log2 unit behind a start/done handshake.
// Euclid by subtract/swap, LCM via restoring divide (a / gcd) then a single multiply by b.
module gcd_lcm_seq_alu #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_ovf,
  output logic             o_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GCD,
    S_DIV,
    S_MUL,
    S_CLOG,
    S_DONE
  } state_t;

  state_t r_state, w_nextState;

  logic [WIDTH-1:0]   r_a, r_b, r_quot, r_bOrig;
  logic [1:0]         r_op;
  logic [WIDTH:0]     r_rem;
  logic [CW-1:0]      r_cnt;
  logic               r_busy, r_done, r_ovf, r_err;
  logic [WIDTH-1:0]   r_result;

  logic [WIDTH:0]     w_remShift, w_remSub;
  logic               w_qBit, w_divLast;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_resultNext;
  logic               w_ovfNext, w_errNext;

  // r_quot starts out holding the dividend (original a) and fills with quotient bits from the right.
  assign w_remShift = {r_rem[WIDTH-1:0], r_quot[WIDTH-1]};
  assign w_remSub   = w_remShift - {1'b0, r_a};
  assign w_qBit     = ~w_remSub[WIDTH];
  assign w_divLast  = (r_cnt == CW'(WIDTH - 1));
  assign w_prod     = {{WIDTH{1'b0}}, r_quot} * {{WIDTH{1'b0}}, r_bOrig};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState  = r_state;
    w_resultNext = '0;
    w_ovfNext    = 1'b0;
    w_errNext    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          case (i_op)
            2'b00, 2'b01: w_nextState = S_GCD;
            2'b10:        w_nextState = S_CLOG;
            default: begin
              w_nextState = S_DONE;
              w_errNext   = 1'b1;
            end
          endcase
        end
      end
      S_GCD: begin
        // Terminates once B has reached zero without needing a swap; A is then the GCD.
        if (!(r_a < r_b) && (r_b == '0)) begin
          if (r_op == 2'b00) begin
            w_nextState  = S_DONE;
            w_resultNext = r_a;
          end else if (r_a == '0) begin
            w_nextState = S_DONE;
          end else begin
            w_nextState = S_DIV;
          end
        end
      end
      S_DIV: begin
        if (w_divLast) w_nextState = S_MUL;
      end
      S_MUL: begin
        w_nextState  = S_DONE;
        w_resultNext = w_prod[WIDTH-1:0];
        w_ovfNext    = |w_prod[2*WIDTH-1:WIDTH];
      end
      S_CLOG: begin
        if (r_a == '0) begin
          w_nextState  = S_DONE;
          w_resultNext = WIDTH'(r_cnt);
        end
      end
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_quot  <= '0;
      r_bOrig <= '0;
      r_op    <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            // CLOG reuses r_a as the shift register T = a-1 (0 when a is 0).
            if (i_op == 2'b10) r_a <= (i_a == '0) ? '0 : i_a - WIDTH'(1);
            else               r_a <= i_a;
            r_b     <= i_b;
            r_quot  <= i_a;
            r_bOrig <= i_b;
            r_op    <= i_op;
            r_rem   <= '0;
            r_cnt   <= '0;
          end
        end
        S_GCD: begin
          if (r_a < r_b) begin
            r_a <= r_b;
            r_b <= r_a;
          end else if (r_b != '0) begin
            r_a <= r_a - r_b;
          end
        end
        S_DIV: begin
          r_rem  <= w_qBit ? w_remSub : w_remShift;
          r_quot <= {r_quot[WIDTH-2:0], w_qBit};
          r_cnt  <= r_cnt + CW'(1);
        end
        S_CLOG: begin
          if (r_a != '0) begin
            r_a   <= r_a >> 1;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Result flags are only touched on entry to DONE, so they hold between operations.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_busy <= (w_nextState == S_GCD) || (w_nextState == S_DIV) ||
                (w_nextState == S_MUL) || (w_nextState == S_CLOG);
      r_done <= (w_nextState == S_DONE);
      if (w_nextState == S_DONE) begin
        r_result <= w_resultNext;
        r_ovf    <= w_ovfNext;
        r_err    <= w_errNext;
      end
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_ovf    = r_ovf;
  assign o_err    = r_err;

endmodule

// File: tb/tb_gcd_lcm_seq_alu.sv
// Scoreboard bench for gcd_lcm_seq_alu: a 32-bit instance for most cases and an 8-bit one for overflow.
module tb_gcd_lcm_seq_alu;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        start = 1'b0;
   logic [1:0]  op    = '0;
   logic [31:0] a     = '0;
   logic [31:0] b     = '0;
   logic        busy, done, ovf, err;
   logic [31:0] result;

   logic        nStart = 1'b0;
   logic [1:0]  nOp    = '0;
   logic [7:0]  nA     = '0;
   logic [7:0]  nB     = '0;
   logic        nBusy, nDone, nOvf, nErr;
   logic [7:0]  nResult;

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      logic        err;
   } exp_t;

   exp_t expQ[$];
   exp_t expNQ[$];
   exp_t wideE, narrowE;

   int checks = 0;
   int errors = 0;
   int lat;
   int seen;
   int lastDone;

   // Free-running 100 MHz clock shared by both instances.
   always #5 clk = ~clk;

   gcd_lcm_seq_alu #(.WIDTH(32)) dutWide (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
      .o_busy(busy), .o_done(done), .o_result(result), .o_ovf(ovf), .o_err(err)
   );

   gcd_lcm_seq_alu #(.WIDTH(8)) dutNarrow (
      .i_clk(clk), .i_rst(rst), .i_start(nStart), .i_op(nOp), .i_a(nA), .i_b(nB),
      .o_busy(nBusy), .o_done(nDone), .o_result(nResult), .o_ovf(nOvf), .o_err(nErr)
   );

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Reference model: modulo Euclid, divide-then-multiply LCM, and a power-of-two search for clog2.
   function automatic exp_t modelOp(input logic [1:0] o, input logic [63:0] x0, input logic [63:0] y0, input int w);
      exp_t e;
      logic [63:0] x, y, t, l, mask;
      int n;
      e.res = '0;
      e.ovf = 1'b0;
      e.err = 1'b0;
      mask  = (64'd1 << w) - 64'd1;
      x = x0;
      y = y0;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      case (o)
         2'b00: e.res = x[31:0];
         2'b01: begin
            l = (x == 0) ? 64'd0 : (x0 / x) * y0;
            t = l & mask;
            e.res = t[31:0];
            e.ovf = ((l >> w) != 0);
         end
         2'b10: begin
            n = 0;
            while ((64'd1 << n) < x0) n++;
            e.res = n;
         end
         default: e.err = 1'b1;
      endcase
      return e;
   endfunction

   // Wide-instance monitor: every done pulse pops one expected entry.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (expQ.size() == 0) checkOutput("spuriousDoneWide", 1, 0);
         else begin
            wideE = expQ.pop_front();
            checkOutput("resultWide", result, wideE.res);
            checkOutput("ovfWide", ovf, wideE.ovf);
            checkOutput("errWide", err, wideE.err);
         end
      end
   end

   // Narrow-instance monitor, same scheme with its own queue.
   always @(negedge clk) begin
      if (!rst && nDone) begin
         if (expNQ.size() == 0) checkOutput("spuriousDoneNarrow", 1, 0);
         else begin
            narrowE = expNQ.pop_front();
            checkOutput("resultNarrow", nResult, narrowE.res);
            checkOutput("ovfNarrow", nOvf, narrowE.ovf);
            checkOutput("errNarrow", nErr, narrowE.err);
         end
      end
   end

   // Issues one request from IDLE, waits (bounded) for done and reports cycles from accept to done.
   task automatic applyStimulus(input bit narrow, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output int latency);
      @(negedge clk);
      if (narrow) begin
         nStart = 1'b1; nOp = o; nA = x[7:0]; nB = y[7:0];
         expNQ.push_back(modelOp(o, {56'd0, x[7:0]}, {56'd0, y[7:0]}, 8));
      end else begin
         start = 1'b1; op = o; a = x; b = y;
         expQ.push_back(modelOp(o, {32'd0, x}, {32'd0, y}, 32));
      end
      @(posedge clk);
      #1;
      nStart = 1'b0;
      start  = 1'b0;
      latency = -1;
      for (int i = 1; i <= 3000; i++) begin
         @(negedge clk);
         if (narrow ? nDone : done) begin
            latency = i;
            break;
         end
      end
      if (latency < 0) checkOutput("doneTimeout", 0, 1);
   endtask

   initial begin
      #12;
      checkOutput("resetWide", {busy, done, ovf, err, result}, 0);
      checkOutput("resetNarrow", {nBusy, nDone, nOvf, nErr, nResult}, 0);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(0, 2'b00, 32'd12, 32'd8, lat);
      checkOutput("gcdLatency", lat, 7);
      applyStimulus(0, 2'b00, 32'd0, 32'd9, lat);
      applyStimulus(0, 2'b00, 32'd0, 32'd0, lat);
      applyStimulus(0, 2'b01, 32'd12, 32'd8, lat);
      applyStimulus(0, 2'b01, 32'd0, 32'd7, lat);
      applyStimulus(0, 2'b01, 32'd0, 32'd0, lat);
      applyStimulus(0, 2'b01, 32'hC000_0000, 32'h8000_0000, lat);
      applyStimulus(0, 2'b10, 32'd0, 32'd3, lat);
      applyStimulus(0, 2'b10, 32'd1, 32'd0, lat);
      applyStimulus(0, 2'b10, 32'd5, 32'd0, lat);
      checkOutput("clogLatency", lat, 5);
      applyStimulus(0, 2'b10, 32'd32, 32'd0, lat);
      applyStimulus(0, 2'b10, 32'hFFFF_FFFF, 32'd0, lat);
      applyStimulus(0, 2'b11, 32'd5, 32'd6, lat);
      checkOutput("illegalLatency", lat, 1);
      applyStimulus(0, 2'b00, 32'd12, 32'd8, lat);

      applyStimulus(1, 2'b01, 32'd200, 32'd3, lat);
      applyStimulus(1, 2'b01, 32'd12, 32'd8, lat);
      applyStimulus(1, 2'b10, 32'd255, 32'd0, lat);
      applyStimulus(1, 2'b11, 32'd1, 32'd1, lat);

      // Abort an LCM with reset three cycles in; nothing is queued so any done would be flagged.
      @(negedge clk);
      start = 1'b1; op = 2'b01; a = 32'd12; b = 32'd8;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1 checkOutput("abortOutputs", {busy, done, ovf, err, result}, 0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(0, 2'b01, 32'd12, 32'd8, lat);

      // Start held high: operands change while busy and only take effect at the next accept.
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd12; b = 32'd8;
      expQ.push_back(modelOp(2'b00, 64'd12, 64'd8, 32));
      expQ.push_back(modelOp(2'b00, 64'd9, 64'd6, 32));
      expQ.push_back(modelOp(2'b00, 64'd9, 64'd6, 32));
      @(posedge clk);
      #1 a = 32'd9; b = 32'd6;
      seen = 0;
      lastDone = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (done) begin
            seen++;
            if (seen > 1) checkOutput("backToBackGap", i - lastDone, 8);
            lastDone = i;
            if (seen == 3) begin
               start = 1'b0;
               break;
            end
         end
      end
      start = 1'b0;
      checkOutput("heldStartDones", seen, 3);

      for (int k = 0; k < 8; k++) begin
         applyStimulus(0, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 300)), 32'($urandom_range(0, 300)), lat);
      end

      repeat (3) @(negedge clk);
      checkOutput("queuesDrained", expQ.size() + expNQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gcd_lcm_seq_alu.md
Name: gcd_lcm_seq_alu

Overview:
- Multi-cycle, parametrised arithmetic unit for the number-theory datapath.
- Computes GCD(a,b), LCM(a,b) and ceil-log2(a) of unsigned WIDTH-bit operands through a start/done handshake.
- Uses a shared subtract/swap Euclid engine, a restoring divider and one multiplier, so no large combinational loops are needed.
- Successor to the single-cycle 32-bit GCD/LCM/clog2 ALU. Adds width generality, an explicit overflow flag and an illegal-op flag.

Parameters:
- WIDTH, 32, operand and result width in bits (minimum 4).
- CW, $clog2(WIDTH+1), width of the internal bit/iteration counters.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  operation: 00 GCD, 01 LCM, 10 CLOG2(a), 11 illegal.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned; ignored for CLOG2.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when result/ovf/err become valid.
- result  output  WIDTH  result; holds its value until the next done.
- ovf  output  1  LCM true value exceeds WIDTH bits; result holds the low WIDTH bits.
- err  output  1  op==11 on the accepted request.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, result=0, ovf=0, err=0; internal registers cleared.
- Reset during an operation aborts it; no done pulse is produced.
- IDLE: on start=1, latch a, b, op into A, B, OP and clear the counters.
  - op 00/01 -> GCD state.
  - op 10 -> CLOG state, with T=a-1 (T=0 if a==0).
  - op 11 -> DONE with result=0, err=1.
- start while busy or in DONE is ignored; the latched operands are not disturbed.
- GCD state: exactly one action per cycle, evaluated in priority order:
  - A<B: swap A and B.
  - else B!=0: A=A-B.
  - else: terminate with G=A. OP 00 -> DONE with result=G. OP 01 -> DIV.
- GCD boundary values: GCD(0,x)=x; GCD(0,0)=0.
- LCM special case: if G==0 (both operands zero), go to DONE with result=0, ovf=0.
- DIV state: restoring division of the original a by G.
  - One quotient bit per cycle, MSB first; exactly WIDTH cycles.
  - Remainder register is WIDTH+1 bits; quotient Q is WIDTH bits.
  - Moves to MUL after the WIDTH-th bit.
- MUL state (1 cycle): P = Q*b, 2*WIDTH bits.
  - result = P[WIDTH-1:0]; ovf = |P[2*WIDTH-1:WIDTH].
  - Moves to DONE.
- A zero operand in LCM yields result 0 (G = the other operand, Q or b = 0).
- CLOG state: each cycle, if T!=0 then T=T>>1 and cnt=cnt+1; else go to DONE with result=cnt zero-extended.
  - clog2(0)=0, clog2(1)=0, clog2(2)=1, clog2(5)=3, clog2(2^WIDTH-1)=WIDTH.
  - Latency is cnt+1 cycles.
- DONE state (1 cycle): done=1, busy=0, then return to IDLE.
  - A start in the following IDLE cycle is accepted, giving back-to-back operation.
- result, ovf and err are registered and update only on entry to DONE. ovf and err are cleared on every new done for the ops that do not set them.
- busy is registered: 1 in GCD, DIV, MUL and CLOG; 0 in IDLE and DONE.

Test Plan:
- Reset mid-LCM: start op=01, a=12, b=8; assert rst 3 cycles later -> all outputs 0 immediately, no done pulse, next request serviced normally.
- GCD: op=00, a=12, b=8 -> steps (12,8)->(4,8)->(8,4)->(4,4)->(0,4)->(4,0)->terminate. GCD state lasts 6 cycles, done pulses once, result=4, ovf=0, err=0.
- LCM and overflow:
  - WIDTH=32, op=01, a=12, b=8 -> result=24, ovf=0.
  - WIDTH=8, a=200, b=3 -> result=600 mod 256=88, ovf=1.
  - a=0, b=7 -> result=0, ovf=0.
- CLOG2: op=10 with a=0 -> 0; a=1 -> 0; a=5 -> 3; a=32 -> 5; a=0xFFFFFFFF -> 32.
- Handshake:
  - start held high continuously -> exactly one accept per DONE→IDLE cycle; pulses during busy are ignored; operand changes while busy do not affect result.
  - op=11 -> done on the 2nd cycle after accept, result=0, err=1.
